uart_io_nios2_qsys_ocimem_ctrl: RTL
===================================

// Module: uart_io_nios2_qsys_ocimem_ctrl
// PURPOSE
//  Debug on-chip memory controller, sysclk domain, downstream of the JTAG debug module sysclk stage.
//  Consumes its jdo/take_*_ocimem_* strobes to load the monitor address and to read/write a debug RAM.
//  Returns MonDReg/monitor_ready/monitor_error to the TCK-side capture path.
//  Gives the CPU an Avalon-MM slave port onto the same RAM; JTAG has priority.
// PARAMETERS
//  ADDR_W   8   RAM word-address width, 1..9; depth = 2**ADDR_W x 32 bit
// PORTS
//  clk                      in   1       system clock; single clock domain
//  reset                    in   1       synchronous, active-high reset
//  jdo                      in   38      JTAG data word from the debug sysclk stage
//  take_action_ocimem_a     in   1       1-cycle strobe: load address / command
//  take_action_ocimem_b     in   1       1-cycle strobe: write jdo data to RAM
//  take_no_action_ocimem_a  in   1       1-cycle strobe: read RAM into MonDReg
//  debugack                 in   1       CPU is in debug mode
//  av_address               in   ADDR_W  CPU word address
//  av_read                  in   1       CPU read request
//  av_write                 in   1       CPU write request
//  av_writedata             in   32      CPU write data
//  av_byteenable            in   4       CPU byte lanes
//  av_readdata              out  32      CPU read data, valid when av_read=1 and av_waitrequest=0
//  av_waitrequest           out  1       stall CPU access (combinational)
//  MonDReg                  out  32      monitor data register to the TCK side
//  monitor_ready            out  1       last JTAG memory operation done
//  monitor_error            out  1       JTAG strobe dropped (protocol violation)
// BEHAVIOUR
//  - Reset: MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, av_readdata=0, state=IDLE.
//  - Reset does not clear RAM contents. Reset mid-read aborts it; no MonDReg/av_readdata update.
//  - RAM is single-port, synchronous, 1-cycle read latency. One access per cycle.
//  - FSM states: IDLE, JRD (JTAG read pending), CRD (CPU read pending).
//  - IDLE priority: ocimem_a > ocimem_b > no_action_ocimem_a > CPU.
//  - Dropped lower-priority strobes set monitor_error.
//  - ocimem_a: MonAReg<=jdo[17+:ADDR_W]; monitor_ready<=0; monitor_error<=0.
//    If jdo[35]=1, also issue a RAM read and go to JRD.
//  - ocimem_b: RAM[MonAReg]<=jdo[34:3] (all lanes); MonAReg++; monitor_ready<=1; stay IDLE.
//  - no_action_ocimem_a: issue RAM read at MonAReg; go to JRD.
//  - JRD (1 cycle): MonDReg<=ram_q; MonAReg++; monitor_ready<=1; go to IDLE.
//  - MonAReg wraps modulo 2**ADDR_W (all-ones -> 0).
//  - CPU in IDLE, no JTAG strobe:
//    write: byte-masked write this cycle, av_waitrequest=0.
//    read: issue RAM read, av_waitrequest=1, go to CRD.
//  - CRD (1 cycle): av_readdata=ram_q, av_waitrequest=0, go to IDLE.
//    CPU read latency is 2 cycles from request.
//  - av_waitrequest=1 whenever a CPU request is pending but not served:
//    JTAG strobe in IDLE, or state JRD.
//  - av_read and av_write both high is treated as a read; the write is ignored.
//  - Any take strobe in JRD or CRD: dropped, monitor_error<=1. The in-flight op completes normally.
//  - av_readdata holds its last value between reads.
// CONFIGURATION
//  UART_IO_OCIMEM_WRPROT_EN defined:
//    CPU writes with debugack=0 are completed (av_waitrequest=0) but discarded.
//    RAM is modifiable by the CPU only in debug mode. JTAG writes are always allowed.
//  UART_IO_OCIMEM_WRPROT_EN undefined: CPU writes always update RAM; debugack is unused.
// TESTING
//  - Reset: reset=1 for 2 cycles -> all outputs 0; MonAReg=0; av_waitrequest=0 with no request.
//  - ocimem_a jdo[17+:8]=0x10, jdo[35]=0; then ocimem_b, jdo[34:3]=0xDEADBEEF
//    -> RAM[0x10]=0xDEADBEEF; MonAReg=0x11; monitor_ready=1.
//  - ocimem_a addr 0x10, jdo[35]=1 -> monitor_ready=0 then 1 two cycles later;
//    MonDReg=0xDEADBEEF; MonAReg=0x11.
//  - Wrap: ocimem_a addr 0xFF, then ocimem_b x2 -> writes at 0xFF then 0x00; MonAReg=0x01.
//  - Contention: CPU read 0x10 in the same cycle as ocimem_b -> av_waitrequest=1 that cycle;
//    read completes 2 cycles later with the updated data.
//  - Overrun: no_action_ocimem_a then ocimem_b next cycle (JRD) -> monitor_error=1; RAM unchanged.
//    Next ocimem_a clears monitor_error.
//  - WRPROT_EN defined: CPU write 0x5 data 0x1234 with debugack=0 -> reads back old value;
//    with debugack=1 -> reads 0x1234.

Source files
------------

// File: rtl/uart_io_nios2_qsys_ocimem_ctrl_if.sv
// Avalon-MM slave bus between the CPU data master and the debug OCI memory.
interface uart_io_nios2_qsys_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/uart_io_nios2_qsys_ocimem_ctrl.sv
// Debug on-chip memory controller: JTAG monitor access plus a CPU Avalon port onto one RAM.
// Optional macro UART_IO_OCIMEM_WRPROT_EN: CPU writes land in RAM only while debugack=1.
module uart_io_nios2_qsys_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [37:0]                        jdo,
  input  logic                               take_action_ocimem_a,
  input  logic                               take_action_ocimem_b,
  input  logic                               take_no_action_ocimem_a,
  input  logic                               debugack,
  uart_io_nios2_qsys_ocimem_ctrl_if.slave    av,
  output logic [31:0]                        MonDReg,
  output logic                               monitor_ready,
  output logic                               monitor_error
);

  typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;

  state_t            state, state_n;
  logic [31:0]       ram [2**ADDR_W];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [31:0]       rd_hold;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re, ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              mon_a_load, mon_a_inc, mon_d_load, rd_hold_load;
  logic              ready_set, ready_clr, err_set, err_clr;
  logic              any_take, cpu_req, cpu_wr_ok;

`ifdef UART_IO_OCIMEM_WRPROT_EN
  assign cpu_wr_ok = debugack;
`else
  logic unused_debugack;
  assign cpu_wr_ok       = 1'b1;
  assign unused_debugack = debugack;
`endif

  logic [4:0] unused_jdo;
  assign unused_jdo = {jdo[37:36], jdo[2:0]};

  assign any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cpu_req  = av.av_read | av.av_write;

  // The CPU sees the RAM output directly in CRD so data is valid with waitrequest low.
  assign av.av_readdata = (state == CRD) ? ram_q : rd_hold;

  always_comb begin
    state_n           = state;
    ram_addr          = mon_a_reg;
    ram_re            = 1'b0;
    ram_we            = 1'b0;
    ram_be            = 4'hF;
    ram_wdata         = jdo[34:3];
    mon_a_load        = 1'b0;
    mon_a_inc         = 1'b0;
    mon_d_load        = 1'b0;
    rd_hold_load      = 1'b0;
    ready_set         = 1'b0;
    ready_clr         = 1'b0;
    err_set           = 1'b0;
    err_clr           = 1'b0;
    av.av_waitrequest = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_load        = 1'b1;
          ready_clr         = 1'b1;
          err_clr           = 1'b1;
          err_set           = take_action_ocimem_b | take_no_action_ocimem_a;
          av.av_waitrequest = cpu_req;
          if (jdo[35]) begin
            ram_addr = jdo[17 +: ADDR_W];
            ram_re   = 1'b1;
            state_n  = JRD;
          end
        end else if (take_action_ocimem_b) begin
          ram_we            = 1'b1;
          mon_a_inc         = 1'b1;
          ready_set         = 1'b1;
          err_set           = take_no_action_ocimem_a;
          av.av_waitrequest = cpu_req;
        end else if (take_no_action_ocimem_a) begin
          ram_re            = 1'b1;
          state_n           = JRD;
          av.av_waitrequest = cpu_req;
        end else if (av.av_read) begin
          ram_addr          = av.av_address;
          ram_re            = 1'b1;
          av.av_waitrequest = 1'b1;
          state_n           = CRD;
        end else if (av.av_write) begin
          ram_addr  = av.av_address;
          ram_we    = cpu_wr_ok;
          ram_be    = av.av_byteenable;
          ram_wdata = av.av_writedata;
        end
      end
      JRD: begin
        mon_d_load        = 1'b1;
        mon_a_inc         = 1'b1;
        ready_set         = 1'b1;
        err_set           = any_take;
        av.av_waitrequest = cpu_req;
        state_n           = IDLE;
      end
      CRD: begin
        rd_hold_load = 1'b1;
        err_set      = any_take;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_hold       <= '0;
    end else begin
      state <= state_n;
      if (mon_a_load)     mon_a_reg <= jdo[17 +: ADDR_W];
      else if (mon_a_inc) mon_a_reg <= mon_a_reg + ADDR_W'(1);
      if (mon_d_load)   MonDReg <= ram_q;
      if (rd_hold_load) rd_hold <= ram_q;
      if (ready_set)      monitor_ready <= 1'b1;
      else if (ready_clr) monitor_ready <= 1'b0;
      if (err_set)      monitor_error <= 1'b1;
      else if (err_clr) monitor_error <= 1'b0;
    end
  end

  // RAM contents survive reset; only the control path is cleared.
  always_ff @(posedge clk) begin
    if (ram_re) ram_q <= ram[ram_addr];
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

endmodule
